// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: latches a bit pattern and shifts it out MSB-first,
// one bit per clock, with optional repetitions separated by idle gap cycles.
//
// state | meaning
// IDLE  | waiting for start with a non-zero pattern length
// SHIFT | presenting pattern bits, current index held in r_idx
// GAP   | idle cycles between repetitions, data_valid low
module serial_pattern_tx #(
  parameter int PAT_W      = 16,
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 2,
  parameter int LEN_W      = ($clog2(PAT_W + 1) < 1) ? 1 : $clog2(PAT_W + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_pat_len,
  input  logic [CNT_W-1:0] i_repeat_cnt,
  input  logic             i_abort,
  output logic             o_data_out,
  output logic             o_data_valid,
  output logic             o_busy,
  output logic             o_done
);

  localparam int IDX_W = ($clog2(PAT_W) < 1) ? 1 : $clog2(PAT_W);
  localparam int GAP_W = ($clog2(GAP_CYCLES + 1) < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  // Gap counter counts down to zero, so it is loaded one short of the gap length.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [IDX_W-1:0] r_last_idx;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_rep;
  logic [GAP_W-1:0] r_gap;
  logic             r_data_out;
  logic             r_data_valid;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W-1:0] w_last_idx;
  logic             w_start_ok;

  // Clamp the requested length to the pattern width and convert it to the MSB index.
  always_comb begin
    w_last_idx = '0;
    if (i_pat_len > LEN_W'(PAT_W)) begin
      w_last_idx = IDX_W'(PAT_W - 1);
    end else begin
      w_last_idx = IDX_W'(i_pat_len - LEN_W'(1));
    end
  end

  assign w_start_ok = i_start && (i_pat_len != '0);

  // Transfer sequencing with all outputs registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_pat        <= '0;
      r_last_idx   <= '0;
      r_idx        <= '0;
      r_rep        <= '0;
      r_gap        <= '0;
      r_data_out   <= 1'b0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_data_out   <= 1'b0;
          r_data_valid <= 1'b0;
          r_busy       <= 1'b0;
          if (w_start_ok) begin
            r_state      <= S_SHIFT;
            r_pat        <= i_pattern;
            r_last_idx   <= w_last_idx;
            r_idx        <= w_last_idx;
            r_rep        <= i_repeat_cnt;
            r_data_out   <= i_pattern[w_last_idx];
            r_data_valid <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (i_abort) begin
            r_state      <= S_IDLE;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_idx != '0) begin
            r_idx      <= r_idx - IDX_W'(1);
            r_data_out <= r_pat[r_idx - IDX_W'(1)];
          end else if (r_rep != '0) begin
            r_rep <= r_rep - CNT_W'(1);
            if (GAP_CYCLES == 0) begin
              r_idx      <= r_last_idx;
              r_data_out <= r_pat[r_last_idx];
            end else begin
              r_state      <= S_GAP;
              r_gap        <= GAP_LOAD;
              r_data_out   <= 1'b0;
              r_data_valid <= 1'b0;
            end
          end else begin
            r_state      <= S_IDLE;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        S_GAP: begin
          if (i_abort) begin
            r_state      <= S_IDLE;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_gap == '0) begin
            r_state      <= S_SHIFT;
            r_idx        <= r_last_idx;
            r_data_out   <= r_pat[r_last_idx];
            r_data_valid <= 1'b1;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_data_out   <= 1'b0;
          r_data_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: table-driven transfers, hand-written corner
// sequences and randomized transfers, all checked against a stream model.
module tb_serial_pattern_tx;

  localparam int PAT_W = 16;
  localparam int CNT_W = 8;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [4:0]       pat_len;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             data_out;
  logic             data_valid;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_pattern_tx #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .GAP_CYCLES(GAP)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_pattern(pattern),
    .i_pat_len(pat_len),
    .i_repeat_cnt(repeat_cnt),
    .i_abort(abort),
    .o_data_out(data_out),
    .o_data_valid(data_valid),
    .o_busy(busy),
    .o_done(done)
  );

  typedef struct {
    logic [15:0] pat;
    logic [4:0]  plen;
    logic [7:0]  rep;
    int          abort_at;
    int          rst_at;
    int          restart_at;
    int          exp_done;
    int          exp_bits;
  } vec_t;

  vec_t       tbl [11];
  logic [3:0] bb  [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Observed outputs packed as {busy, valid, data, done}.
  function automatic logic [3:0] obs();
    return {busy, data_valid, data_out, done};
  endfunction

  // Called right after a negedge. Builds the expected cycle-by-cycle stream for
  // the request, then drives start and checks each cycle after edges E0, E1, ...
  task automatic run_xfer(input string tag, input logic [15:0] pat, input logic [4:0] plen,
                          input logic [7:0] rep, input int abort_at, input int rst_at,
                          input int restart_at, output int done_edge, output int nbits);
    logic [3:0] q[$];
    int len;
    int cut;
    len = (plen > 5'd16) ? 16 : int'(plen);
    if (len > 0) begin
      for (int r = 0; r <= int'(rep); r++) begin
        for (int i = len - 1; i >= 0; i--) q.push_back({1'b1, 1'b1, pat[i], 1'b0});
        if (r < int'(rep)) for (int g = 0; g < GAP; g++) q.push_back(4'b1000);
      end
      q.push_back(4'b0001);
    end
    cut = -1;
    if (abort_at >= 0) cut = abort_at;
    if (rst_at >= 0) cut = rst_at;
    if (cut >= 0 && cut < q.size()) begin
      while (q.size() > cut) void'(q.pop_back());
      q.push_back(4'b0000);
    end
    for (int i = 0; i < 3; i++) q.push_back(4'b0000);

    done_edge  = -1;
    nbits      = 0;
    pattern    = pat;
    pat_len    = plen;
    repeat_cnt = rep;
    start      = 1'b1;
    abort      = 1'b0;
    rst        = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      check($sformatf("%s_cycle%0d", tag, k), {28'd0, obs()}, {28'd0, q[k]});
      if (done && done_edge < 0) done_edge = k;
      if (data_valid) nbits++;
      start      = (restart_at == k + 1);
      abort      = (abort_at == k + 1);
      rst        = (rst_at == k + 1);
      pattern    = PAT_W'($urandom);
      pat_len    = 5'($urandom_range(0, 31));
      repeat_cnt = CNT_W'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    int de;
    int nb;

    tbl[0]  = '{16'h0034,  5'd6, 8'd0,   -1, -1, -1,   6,   6};
    tbl[1]  = '{16'h0034,  5'd6, 8'd1,   -1, -1, -1,  14,  12};
    tbl[2]  = '{16'h5AB5, 5'd20, 8'd0,   -1, -1, -1,  16,  16};
    tbl[3]  = '{16'h0034,  5'd0, 8'd0,   -1, -1, -1,  -1,   0};
    tbl[4]  = '{16'h0034,  5'd6, 8'd0,   -1, -1,  3,   6,   6};
    tbl[5]  = '{16'h0034,  5'd6, 8'd0,    3, -1, -1,  -1,   3};
    tbl[6]  = '{16'h0034,  5'd6, 8'd1,   -1,  7, -1,  -1,   6};
    tbl[7]  = '{16'h0001,  5'd1, 8'd2,   -1, -1, -1,   7,   3};
    tbl[8]  = '{16'hFFFF, 5'd16, 8'd3,   -1, -1, -1,  70,  64};
    tbl[9]  = '{16'h0003,  5'd1, 8'd255, -1, -1, -1, 766, 256};
    tbl[10] = '{16'h0034,  5'd6, 8'd1,    7, -1, -1,  -1,   6};

    bb = '{4'b1110, 4'b1110, 4'b1100, 4'b1110, 4'b1100, 4'b1100, 4'b0001,
           4'b1100, 4'b1110, 4'b1100, 4'b0001};

    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    pattern    = '0;
    pat_len    = '0;
    repeat_cnt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'd0, obs()}, 32'd0);
    rst   = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("abort_idle", {28'd0, obs()}, 32'd0);
    abort = 1'b0;

    for (int t = 0; t < 11; t++) begin
      run_xfer($sformatf("tbl%0d", t), tbl[t].pat, tbl[t].plen, tbl[t].rep, tbl[t].abort_at,
               tbl[t].rst_at, tbl[t].restart_at, de, nb);
      check($sformatf("tbl%0d_done_edge", t), de, tbl[t].exp_done);
      check($sformatf("tbl%0d_nbits", t), nb, tbl[t].exp_bits);
    end

    // start held high through the done cycle: second transfer begins right after it
    pattern    = 16'h0034;
    pat_len    = 5'd6;
    repeat_cnt = 8'd0;
    start      = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check($sformatf("b2b_cycle%0d", k), {28'd0, obs()}, {28'd0, bb[k]});
      if (k == 6) begin
        pattern = 16'h0002;
        pat_len = 5'd3;
      end
      if (k == 7) start = 1'b0;
    end
    repeat (2) begin
      @(negedge clk);
      check("b2b_idle", {28'd0, obs()}, 32'd0);
    end

    for (int t = 0; t < 40; t++) begin
      logic [15:0] rp;
      logic [4:0]  rl;
      logic [7:0]  rr;
      int          ra;
      rp = 16'($urandom);
      rl = 5'($urandom_range(0, 20));
      rr = 8'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
      run_xfer($sformatf("rnd%0d", t), rp, rl, rr, ra, -1, -1, de, nb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
